gb_cpu_scheduler: RTL and testbench
===================================

# gb_cpu_scheduler

Per-M-cycle instruction sequencer for the Game Boy CPU core. Each clock it takes the decoder's `schedule_t` (instruction length, per-M-cycle control words, CB-prefix flag) and the current M-cycle index, and produces the next M-cycle index as a register and the control word for that cycle combinationally. It sits between the instruction decoder and the datapath (register file, IDU, ALU, bus interface). It also tracks whether the next opcode belongs to the CB-prefixed table.

## Interface
- No parameters. `schedule_t` and `control_signals_t` come from `gb_cpu_common_pkg`.
- `schedule_t` fields:
  - `m_cycles` [2:0]: index of the last M-cycle, i.e. instruction length minus 1.
  - `cb_prefix_next`: the opcode being executed is 0xCB.
  - `instruction_controls[0:5]`: one `control_signals_t` per M-cycle.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `schedule` in `schedule_t`: current decoder output.
- `curr_m_cycle` in 3: M-cycle index now executing. Normally fed back from `next_m_cycle`.
- `cond_not_met` in 1: condition-code check of the current cycle failed.
- `control_next` out `control_signals_t`: control word for the cycle selected by the next index.
- `next_m_cycle` out 3: registered M-cycle index.
- `cb_prefix_o` out 1: registered flag; the next decoded opcode uses the CB table.

## Operation
- Effective last index: `last = min(schedule.m_cycles, 5)`. Values 6–7 clamp to 5.
- Current index: `idx = min(curr_m_cycle, 5)`.
- Early termination: `early_end = cond_not_met && schedule.instruction_controls[idx].cc_check`. `cond_not_met` is ignored when `cc_check` is 0.
- Instruction end: `end_of_instr = (curr_m_cycle >= last) || early_end`.
- Next index (combinational): `n = end_of_instr ? 0 : curr_m_cycle + 1`.
- `control_next = schedule.instruction_controls[n]`, purely combinational, all fields passed through unmodified, including X values.
- Register updates on each rising edge when not in reset:
  - `next_m_cycle <= n`.
  - If `end_of_instr`: `cb_prefix_o <= schedule.cb_prefix_next`. Otherwise `cb_prefix_o` holds.
- `cb_prefix_o` therefore changes only at instruction boundaries. A 0xCB opcode sets it for exactly the following instruction; that instruction's boundary reloads it from its own `cb_prefix_next`, normally 0.
- Single-cycle instruction (`m_cycles = 0`): every edge is a boundary, and `next_m_cycle` stays 0.

## Timing
- Reset asserted (`reset = 0`): `next_m_cycle = 0` and `cb_prefix_o = 0` immediately, independent of `clk`.
- Reset release: the first rising edge evaluates normally from `curr_m_cycle = 0`.
- Reset asserted mid-instruction aborts the instruction; the sequence restarts at index 0.
- Latency: `next_m_cycle` updates one clock after its inputs. `control_next` follows `schedule`, `curr_m_cycle` and `cond_not_met` with zero cycles of latency.
- With feedback (`curr_m_cycle = next_m_cycle`), the index sequence is 0,1,…,last,0,… with period `last + 1` clocks.
- Simultaneous events:
  - `cond_not_met` together with `curr_m_cycle = last`: next index is 0; same result as a normal end.
  - `cb_prefix_next` changing mid-instruction has no effect until the boundary edge.
- `curr_m_cycle > last`: treated as an end, so the next index is 0 (recovery from a bad index).
- There are no combinational paths from `curr_m_cycle` to `next_m_cycle` or `cb_prefix_o`.

## Test plan
- **Length-3 loop.** Feedback, `m_cycles = 2`, `cc_check = 0` in all entries, release reset.
  - `next_m_cycle` runs 1,2,0,1,2,0 on successive edges.
  - `control_next` shows entries [1],[2],[0]: e.g. `alu_opcode` SBC at index 0, DAA at 1, RRA at 2.
- **CB prefix.** Same setup; hold `cb_prefix_next = 1` for 3 clocks, then 0 for 6.
  - `cb_prefix_o` goes 1 only on the edge where the index wraps to 0.
  - It returns to 0 at the next wrap after `cb_prefix_next` falls.
  - It never changes mid-instruction.
- **Early termination.** `m_cycles = 5`, entry[2] has `cc_check = 1`, assert `cond_not_met` at index 2.
  - Index goes 0,1,2,0.
  - `cond_not_met` at index 1, where `cc_check = 0`, does not truncate: the index reaches 2.
- **Async reset.** Assert `reset = 0` between edges at index 2 with `cb_prefix_o = 1`.
  - Both outputs go to 0 before the next edge.
  - After release the sequence restarts 1,2,0.
- **Single-cycle and clamp.**
  - `m_cycles = 0`: `next_m_cycle` stays 0 and `control_next` equals entry[0].
  - `m_cycles = 7`: index runs 0..5 then wraps to 0.
- **Out-of-range index.** Force `curr_m_cycle = 4` with `m_cycles = 2` → `next_m_cycle = 0` on the next edge.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the Game Boy CPU core: per-M-cycle control word and the
// decoder's instruction schedule.
package gb_cpu_common_pkg;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_ADC  = 5'd2,
    ALU_SUB  = 5'd3,
    ALU_SBC  = 5'd4,
    ALU_AND  = 5'd5,
    ALU_XOR  = 5'd6,
    ALU_OR   = 5'd7,
    ALU_CP   = 5'd8,
    ALU_INC  = 5'd9,
    ALU_DEC  = 5'd10,
    ALU_RLCA = 5'd11,
    ALU_RRCA = 5'd12,
    ALU_RLA  = 5'd13,
    ALU_RRA  = 5'd14,
    ALU_DAA  = 5'd15,
    ALU_CPL  = 5'd16,
    ALU_SCF  = 5'd17,
    ALU_CCF  = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    ADDR_PC  = 2'd0,
    ADDR_SP  = 2'd1,
    ADDR_HL  = 2'd2,
    ADDR_WZ  = 2'd3
  } addr_src_e;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_op_e;

  typedef enum logic [1:0] {
    IDU_NONE = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2
  } idu_op_e;

  typedef struct packed {
    alu_op_e    alu_opcode;
    addr_src_e  addr_src;
    bus_op_e    bus_op;
    idu_op_e    idu_op;
    logic [3:0] reg_wr_sel;
    logic [3:0] reg_rd_sel;
    logic       cc_check;
    logic [1:0] cc_sel;
    logic [1:0] ime_op;
  } control_signals_t;

  typedef struct packed {
    logic [2:0]                   m_cycles;
    logic                         cb_prefix_next;
    control_signals_t [0:5]       instruction_controls;
  } schedule_t;

endpackage

// File: rtl/gb_cpu_scheduler.sv
// Per-M-cycle sequencer: registers the next M-cycle index and the CB-table flag,
// and muxes out the control word for the cycle the next index selects.
module gb_cpu_scheduler
  import gb_cpu_common_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  schedule_t        schedule,
  input  logic [2:0]       curr_m_cycle,
  input  logic             cond_not_met,
  output control_signals_t control_next,
  output logic [2:0]       next_m_cycle,
  output logic             cb_prefix_o
);

  logic [2:0] next_m_cycle_d, next_m_cycle_q;
  logic       cb_prefix_d, cb_prefix_q;
  logic [2:0] last;
  logic [2:0] idx;
  logic       early_end;
  logic       end_of_instr;

  // Only six control entries exist, so indices 6-7 collapse onto the last one.
  function automatic logic [2:0] clamp5(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  always_comb begin
    last           = clamp5(schedule.m_cycles);
    idx            = clamp5(curr_m_cycle);
    early_end      = cond_not_met && schedule.instruction_controls[idx].cc_check;
    // An index past the end is treated as a boundary so a bad index recovers.
    end_of_instr   = (curr_m_cycle >= last) || early_end;
    next_m_cycle_d = end_of_instr ? 3'd0 : (curr_m_cycle + 3'd1);
    cb_prefix_d    = end_of_instr ? schedule.cb_prefix_next : cb_prefix_q;
    control_next   = schedule.instruction_controls[next_m_cycle_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_m_cycle_q <= 3'd0;
      cb_prefix_q    <= 1'b0;
    end else begin
      next_m_cycle_q <= next_m_cycle_d;
      cb_prefix_q    <= cb_prefix_d;
    end
  end

  assign next_m_cycle = next_m_cycle_q;
  assign cb_prefix_o  = cb_prefix_q;

endmodule

// File: tb/tb_gb_cpu_scheduler.sv
// Self-checking bench for gb_cpu_scheduler: directed scenarios from fixed
// expected tables plus a randomized run against a rule-level reference model.
module tb_gb_cpu_scheduler;
  import gb_cpu_common_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  schedule_t        schedule;
  logic [2:0]       curr_force;
  logic             fb;
  logic             cond_not_met;
  logic [2:0]       curr_m_cycle;
  control_signals_t control_next;
  logic [2:0]       next_m_cycle;
  logic             cb_prefix_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_idx  = 0;
  logic mdl_cb   = 1'b0;

  always #5 clk = ~clk;

  assign curr_m_cycle = fb ? next_m_cycle : curr_force;

  gb_cpu_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .schedule     (schedule),
    .curr_m_cycle (curr_m_cycle),
    .cond_not_met (cond_not_met),
    .control_next (control_next),
    .next_m_cycle (next_m_cycle),
    .cb_prefix_o  (cb_prefix_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic control_signals_t rand_ctrl(input bit cc);
    logic [31:0]      r;
    control_signals_t c;
    r = $urandom;
    c = control_signals_t'(r[$bits(control_signals_t)-1:0]);
    c.cc_check = cc;
    return c;
  endfunction

  function automatic schedule_t rand_sched(input int mc, input logic [5:0] ccmask);
    schedule_t s;
    s.m_cycles       = 3'(mc);
    s.cb_prefix_next = 1'b0;
    for (int i = 0; i < 6; i++) s.instruction_controls[i] = rand_ctrl(ccmask[i]);
    return s;
  endfunction

  // Reference: an instruction occupies cycles 0..min(len-1,5); it ends at its
  // last cycle, at any index beyond it, or where a checked condition fails.
  function automatic int model_next();
    int cur, last, idx;
    bit early;
    cur   = fb ? mdl_idx : int'(curr_force);
    last  = (int'(schedule.m_cycles) > 5) ? 5 : int'(schedule.m_cycles);
    idx   = (cur > 5) ? 5 : cur;
    early = cond_not_met && schedule.instruction_controls[idx].cc_check;
    if (cur >= last || early) return 0;
    return cur + 1;
  endfunction

  task automatic advance();
    int   n;
    logic cb;
    n  = model_next();
    cb = (n == 0) ? schedule.cb_prefix_next : mdl_cb;
    @(posedge clk);
    mdl_idx = n;
    mdl_cb  = cb;
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    fb           = 1'b0;
    curr_force   = 3'd3;
    cond_not_met = 1'b1;
    schedule     = rand_sched(5, 6'h3f);
    schedule.cb_prefix_next = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (next_m_cycle !== 3'd0) begin
      n_fail++; $display("FAIL reset_idx: got %0d required 0", next_m_cycle);
    end
    n_checks++;
    if (cb_prefix_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_cb: got %b required 0", cb_prefix_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (next_m_cycle !== 3'd0 || cb_prefix_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got idx=%0d cb=%b required idx=0 cb=0", next_m_cycle, cb_prefix_o);
      end
    end
    mdl_idx = 0;
    mdl_cb  = 1'b0;
  endtask

  task automatic test_loop3();
    int      exp_seq[6] = '{1, 2, 0, 1, 2, 0};
    alu_op_e exp_alu[6] = '{ALU_RRA, ALU_SBC, ALU_DAA, ALU_RRA, ALU_SBC, ALU_DAA};
    schedule = rand_sched(2, 6'h00);
    schedule.instruction_controls[0].alu_opcode = ALU_SBC;
    schedule.instruction_controls[1].alu_opcode = ALU_DAA;
    schedule.instruction_controls[2].alu_opcode = ALU_RRA;
    cond_not_met = 1'b0;
    fb           = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (control_next.alu_opcode !== ALU_DAA) begin
      n_fail++; $display("FAIL loop3_first_ctrl: got %0d required %0d", control_next.alu_opcode, ALU_DAA);
    end
    for (int k = 0; k < 6; k++) begin
      advance();
      n_checks++;
      if (next_m_cycle !== 3'(exp_seq[k])) begin
        n_fail++; $display("FAIL loop3_idx[%0d]: got %0d required %0d", k, next_m_cycle, exp_seq[k]);
      end
      n_checks++;
      if (control_next.alu_opcode !== exp_alu[k]) begin
        n_fail++; $display("FAIL loop3_alu[%0d]: got %0d required %0d", k, control_next.alu_opcode, exp_alu[k]);
      end
    end
  endtask

  task automatic test_cb_prefix();
    logic cb_in[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic cb_exp[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      schedule.cb_prefix_next = cb_in[k];
      advance();
      n_checks++;
      if (cb_prefix_o !== cb_exp[k]) begin
        n_fail++; $display("FAIL cb_prefix[%0d]: got %b required %b", k, cb_prefix_o, cb_exp[k]);
      end
    end
  endtask

  task automatic test_early_term();
    schedule     = rand_sched(5, 6'b000100);
    cond_not_met = 1'b1;
    advance();
    n_checks++;
    if (next_m_cycle !== 3'd1) begin
      n_fail++; $display("FAIL early_idx0: got %0d required 1", next_m_cycle);
    end
    advance();
    n_checks++;
    if (next_m_cycle !== 3'd2) begin
      n_fail++; $display("FAIL early_no_cc: got %0d required 2", next_m_cycle);
    end
    n_checks++;
    if (control_next !== schedule.instruction_controls[0]) begin
      n_fail++; $display("FAIL early_ctrl: got %h required %h", control_next, schedule.instruction_controls[0]);
    end
    advance();
    n_checks++;
    if (next_m_cycle !== 3'd0) begin
      n_fail++; $display("FAIL early_end: got %0d required 0", next_m_cycle);
    end
    cond_not_met = 1'b0;
  endtask

  task automatic test_async_reset();
    int exp_seq[3] = '{1, 2, 0};
    schedule = rand_sched(2, 6'h00);
    schedule.cb_prefix_next = 1'b1;
    for (int k = 0; k < 3; k++) advance();
    schedule.cb_prefix_next = 1'b0;
    for (int k = 0; k < 2; k++) advance();
    n_checks++;
    if (next_m_cycle !== 3'd2 || cb_prefix_o !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got idx=%0d cb=%b required idx=2 cb=1", next_m_cycle, cb_prefix_o);
    end
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (next_m_cycle !== 3'd0 || cb_prefix_o !== 1'b0) begin
      n_fail++; $display("FAIL areset_async: got idx=%0d cb=%b required idx=0 cb=0", next_m_cycle, cb_prefix_o);
    end
    #2 reset = 1'b1;
    mdl_idx = 0;
    mdl_cb  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      advance();
      n_checks++;
      if (next_m_cycle !== 3'(exp_seq[k]) || cb_prefix_o !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_restart[%0d]: got idx=%0d cb=%b required idx=%0d cb=0", k, next_m_cycle, cb_prefix_o, exp_seq[k]);
      end
    end
  endtask

  task automatic test_single_and_clamp();
    logic cbv;
    schedule = rand_sched(0, 6'($urandom));
    for (int k = 0; k < 6; k++) begin
      cbv                     = 1'($urandom);
      schedule.cb_prefix_next = cbv;
      cond_not_met            = 1'($urandom);
      #1;
      n_checks++;
      if (control_next !== schedule.instruction_controls[0]) begin
        n_fail++; $display("FAIL single_ctrl[%0d]: got %h required %h", k, control_next, schedule.instruction_controls[0]);
      end
      advance();
      n_checks++;
      if (next_m_cycle !== 3'd0 || cb_prefix_o !== cbv) begin
        n_fail++;
        $display("FAIL single_idx[%0d]: got idx=%0d cb=%b required idx=0 cb=%b", k, next_m_cycle, cb_prefix_o, cbv);
      end
    end
    schedule     = rand_sched(7, 6'h00);
    cond_not_met = 1'b0;
    for (int k = 0; k < 12; k++) begin
      advance();
      n_checks++;
      if (next_m_cycle !== 3'((k + 1) % 6)) begin
        n_fail++; $display("FAIL clamp_idx[%0d]: got %0d required %0d", k, next_m_cycle, (k + 1) % 6);
      end
    end
  endtask

  task automatic test_out_of_range();
    int bad_idx[3] = '{4, 7, 3};
    int bad_mc[3]  = '{2, 7, 0};
    fb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      schedule                = rand_sched(bad_mc[k], 6'h00);
      schedule.cb_prefix_next = 1'b1;
      curr_force              = 3'(bad_idx[k]);
      #1;
      n_checks++;
      if (control_next !== schedule.instruction_controls[0]) begin
        n_fail++; $display("FAIL oor_ctrl[%0d]: got %h required %h", k, control_next, schedule.instruction_controls[0]);
      end
      advance();
      n_checks++;
      if (next_m_cycle !== 3'd0 || cb_prefix_o !== 1'b1) begin
        n_fail++;
        $display("FAIL oor_idx[%0d]: got idx=%0d cb=%b required idx=0 cb=1", k, next_m_cycle, cb_prefix_o);
      end
    end
  endtask

  task automatic test_random();
    control_signals_t exp_ctrl;
    for (int k = 0; k < 400; k++) begin
      fb         = ($urandom_range(0, 7) != 0);
      curr_force = 3'($urandom);
      if ($urandom_range(0, 3) == 0) schedule = rand_sched($urandom_range(0, 7), 6'($urandom));
      schedule.cb_prefix_next = 1'($urandom);
      cond_not_met            = 1'($urandom);
      #1;
      exp_ctrl = schedule.instruction_controls[model_next()];
      n_checks++;
      if (control_next !== exp_ctrl) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %h required %h", k, control_next, exp_ctrl);
      end
      advance();
      n_checks++;
      if (next_m_cycle !== 3'(mdl_idx) || cb_prefix_o !== mdl_cb) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got idx=%0d cb=%b required idx=%0d cb=%b", k, next_m_cycle, cb_prefix_o, mdl_idx, mdl_cb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop3();
    test_cb_prefix();
    test_early_term();
    test_async_reset();
    test_single_and_clamp();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
